// File: rtl/btn_emu_pkg.sv
// btn_emu_pkg: shared state encoding and LFSR constants for the button emulator
package btn_emu_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESS_BNC = 2'b01,
    HELD      = 2'b11,
    REL_BNC   = 2'b10
  } state_t;
  localparam logic [7:0] LFSR_TAPS    = 8'b1011_1000;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;
endpackage

// File: rtl/lfsr8_fib.sv
// lfsr8_fib: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, steps only when enabled
module lfsr8_fib
  import btn_emu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  // shift left, feeding back the xor of the tapped bits
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= seed;
    else if (en) q <= {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/button_bounce_gen.sv
// button_bounce_gen: turns a press request into a bouncy mechanical-switch waveform
module button_bounce_gen
  import btn_emu_pkg::*;
#(
  parameter int          BOUNCE_CYCLES = 8,
  parameter int          HOLD_CYCLES   = 16,
  parameter logic [7:0]  SEED          = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic b,
  output logic busy,
  output logic done
);
  localparam int MAX_C = BOUNCE_CYCLES > HOLD_CYCLES ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W = MAX_C > 1 ? $clog2(MAX_C) : 1;
  localparam logic [CNT_W-1:0] BNC_LD  = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic b_n, done_n, step;
  logic [7:0] lfsr;
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[6:0];
  assign busy = state != IDLE;
  lfsr8_fib u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (step),
    .seed (SEED),
    .q    (lfsr)
  );
  // next state: every bounce cycle emits lfsr[7] and advances the LFSR
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    b_n     = b;
    done_n  = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        b_n = 1'b0;
        if (press) begin
          b_n     = lfsr[7];
          step    = 1'b1;
          cnt_n   = BNC_LD;
          state_n = PRESS_BNC;
        end
      end
      PRESS_BNC: begin
        if (cnt != '0) begin
          b_n   = lfsr[7];
          step  = 1'b1;
          cnt_n = cnt - CNT_W'(1);
        end else begin
          b_n     = 1'b1;
          cnt_n   = HOLD_LD;
          state_n = HELD;
        end
      end
      HELD: begin
        if (cnt != '0) begin
          b_n   = 1'b1;
          cnt_n = cnt - CNT_W'(1);
        end else begin
          b_n     = lfsr[7];
          step    = 1'b1;
          cnt_n   = BNC_LD;
          state_n = REL_BNC;
        end
      end
      default: begin
        if (cnt != '0) begin
          b_n   = lfsr[7];
          step  = 1'b1;
          cnt_n = cnt - CNT_W'(1);
        end else begin
          b_n     = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end
  // state, counter and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      b     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      b     <= b_n;
      done  <= done_n;
    end
endmodule

// File: tb/tb_button_bounce_gen.sv
// tb_button_bounce_gen: directed scenario tests for button_bounce_gen
module tb_button_bounce_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic press = 1'b0;
  logic press_min = 1'b0;
  logic b, busy, done, b_min, busy_min, done_min;
  int vecs = 0;
  int errs = 0;
  logic [7:0] m = 8'hA5;
  logic [3:0] first4;

  always #5 clk = ~clk;

  button_bounce_gen #(.BOUNCE_CYCLES(8), .HOLD_CYCLES(16), .SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .press(press), .b(b), .busy(busy), .done(done)
  );

  button_bounce_gen #(.BOUNCE_CYCLES(1), .HOLD_CYCLES(1), .SEED(8'hA5)) u_min (
    .clk(clk), .rst(rst), .press(press_min), .b(b_min), .busy(busy_min), .done(done_min)
  );

  // entered at the first negedge after press was accepted; ends on the done cycle
  task automatic expect_seq(input string tag, input bit inject);
    logic eb;
    int k;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < 8 || i >= 24) begin
        eb = m[7];
        m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        if (k < 4) begin
          first4[3-k] = b;
          k++;
        end
      end else eb = 1'b1;
      vecs++;
      if (b !== eb || busy !== 1'b1 || done !== 1'b0) begin
        errs++;
        $display("FAIL %s cyc %0d: got b=%b busy=%b done=%b, want b=%b busy=1 done=0", tag, i, b, busy, done, eb);
      end
      if (inject) press = (i == 2 || i == 9 || i == 19);
      @(negedge clk);
    end
    vecs++;
    if (b !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errs++;
      $display("FAIL %s end: got b=%b busy=%b done=%b, want b=0 busy=0 done=1", tag, b, busy, done);
    end
  endtask

  task automatic check_idle(input string tag);
    vecs++;
    if (b !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL %s idle: got b=%b busy=%b done=%b, want 0 0 0", tag, b, busy, done);
    end
  endtask

  task automatic check_first4(input string tag);
    vecs++;
    if (first4 !== 4'b1010) begin
      errs++;
      $display("FAIL %s first4: got %b, want 1010", tag, first4);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    press = 1'b1;
    @(negedge clk);
    press = 1'b0;
    expect_seq("single", 1'b0);
    check_first4("single");
    @(negedge clk);
    check_idle("single_after");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    press = 1'b1;
    @(negedge clk);
    expect_seq("b2b0", 1'b0);
    @(negedge clk);
    expect_seq("b2b1", 1'b0);
    @(negedge clk);
    expect_seq("b2b2", 1'b0);
    press = 1'b0;
    @(negedge clk);
    check_idle("b2b_after");
  endtask

  task automatic test_ignored_press();
    @(negedge clk);
    press = 1'b1;
    @(negedge clk);
    press = 1'b0;
    expect_seq("ignored", 1'b1);
    press = 1'b0;
    @(negedge clk);
    check_idle("ignored_after");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    press = 1'b1;
    @(negedge clk);
    press = 1'b0;
    repeat (15) @(negedge clk);
    vecs++;
    if (b !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL held_pre: got b=%b busy=%b, want 1 1", b, busy);
    end
    #2 rst = 1'b1;
    #1 check_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    m = 8'hA5;
    @(negedge clk);
    press = 1'b1;
    @(negedge clk);
    press = 1'b0;
    expect_seq("post_rst", 1'b0);
    check_first4("post_rst");
  endtask

  task automatic test_min_params();
    logic [3:0] eb, ebusy, edone;
    eb = 4'b1100;
    ebusy = 4'b1110;
    edone = 4'b0001;
    @(negedge clk);
    press_min = 1'b1;
    @(negedge clk);
    press_min = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (b_min !== eb[3-i] || busy_min !== ebusy[3-i] || done_min !== edone[3-i]) begin
        errs++;
        $display("FAIL min cyc %0d: got b=%b busy=%b done=%b, want b=%b busy=%b done=%b",
                 i, b_min, busy_min, done_min, eb[3-i], ebusy[3-i], edone[3-i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored_press();
    test_async_reset();
    test_min_params();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/button_bounce_gen.md
Name: button_bounce_gen

Overview:
- Transmit-side counterpart to the team's button debouncer: turns a clean one-cycle press request into a realistic mechanical-switch waveform on `b`.
- Each press produces leading contact bounce, a stable held level, trailing release bounce, then a settled zero.
- Bounce pattern comes from an 8-bit Fibonacci LFSR, so it is pseudo-random but deterministic per seed.
- Sits in front of the debounce FSM in sim/FPGA self-test builds, replacing the physical push-button.

Parameters:
- BOUNCE_CYCLES, 8: cycles of bounce on each edge (press and release); legal range ≥1.
- HOLD_CYCLES, 16: cycles `b` is held stably at 1 between the two bounce phases; legal range ≥1.
- SEED, 8'hA5: LFSR reset value; must be non-zero.
- CNT_W, derived localparam: clog2 of max(BOUNCE_CYCLES, HOLD_CYCLES), minimum 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- press  input  1  press request; sampled only in IDLE.
- b  output  1  emulated raw button level (registered).
- busy  output  1  high while a press sequence is in progress (state != IDLE).
- done  output  1  one-cycle pulse on the first IDLE cycle after a sequence ends.

Behaviour:
- Reset (asynchronous, immediate, including mid-sequence):
  - state=IDLE, b=0, busy=0, done=0, cnt=0, lfsr=SEED.
  - The LFSR is not re-randomised; every post-reset sequence is identical.
- LFSR step (taps x^8+x^6+x^5+x^4+1):
  - fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]; lfsr <= {lfsr[6:0], fb}.
  - The bounce sample is lfsr[7] before the step.
  - The LFSR steps only on cycles that emit a bounce sample; it holds otherwise.
- States: IDLE, PRESS_BNC, HELD, REL_BNC. The `done` register defaults to 0 every cycle unless set below.
- IDLE: b=0.
  - press=1: b<=sample, step, cnt<=BOUNCE_CYCLES-1, go to PRESS_BNC.
  - press=0: stay.
- PRESS_BNC:
  - cnt!=0: b<=sample, step, cnt--.
  - cnt==0: b<=1, cnt<=HOLD_CYCLES-1, go to HELD.
- HELD:
  - cnt!=0: b stays 1, cnt--.
  - cnt==0: b<=sample, step, cnt<=BOUNCE_CYCLES-1, go to REL_BNC.
- REL_BNC:
  - cnt!=0: b<=sample, step, cnt--.
  - cnt==0: b<=0, done<=1, go to IDLE.
- Timing: `b` shows exactly BOUNCE_CYCLES bounce samples, then HOLD_CYCLES ones, then BOUNCE_CYCLES bounce samples, then 0. Total busy = 2*BOUNCE_CYCLES + HOLD_CYCLES cycles.
- `busy` is registered with the state, so it rises the cycle after press is accepted.
- `press` while busy is ignored, not queued.
- `press` during the `done` cycle (state already IDLE) is accepted: back-to-back sequences are allowed with one IDLE cycle of b=0 between them.
- Minimum parameters (1,1,1): one bounce sample, one cycle of 1, one bounce sample; total 3 cycles.

Decomposition:
- Package btn_emu_pkg holds:
  - the 2-bit state encoding localparams (IDLE=2'b00, PRESS_BNC=2'b01, HELD=2'b11, REL_BNC=2'b10);
  - the LFSR tap constant 8'b1011_1000;
  - the default seed.
- Sub-module lfsr8_fib (ports: clk, rst, en, seed, q[7:0]) encapsulates the Fibonacci register so the LFSR is shared with other LFSR users in the codebase.
- The FSM and counter live in the top module.

Test Plan:
- Reset, then a single press pulse (SEED=A5, BOUNCE=8, HOLD=16) → b samples start 1,0,1,0 (LFSR A5→4A→95→2A→54); busy high exactly 32 cycles; done a single pulse; b=0 afterwards.
- press held high continuously for 100 cycles → back-to-back sequences separated by exactly one b=0 IDLE cycle; each sequence's bounce differs (LFSR continues); done pulses once per sequence.
- press pulsed at cycles 3, 10 and 20 of a sequence → ignored; busy length unchanged; only one done pulse.
- rst asserted asynchronously mid-HELD → b, busy and done drop to 0 before the next clock edge; a following press reproduces the exact post-reset pattern 1,0,1,0.
- BOUNCE=1, HOLD=1 → press accepted; busy for exactly 3 cycles; b = sample, 1, sample, then 0.
- Output feeding the debounce FSM with HOLD ≥ 2 → exactly one debounced d pulse per sequence, occurring after the REL_BNC phase.
